// File: rtl/seq_divider_pkg.sv
// Shared core package: the FSM state type used by the sequential divider
// and, in future, the sequential multiplier.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } core_fsm_e;

    localparam int DIV_SIZE_DEFAULT = 33;

    // Iteration counter width able to hold every value from 0 to size.
    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle, with signed
// fix-up and divide-by-zero shortcut, on a start/ready/valid handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic            is_signed,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            ready,
    output logic            valid,
    output logic            error,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
);

    localparam int              CNT_W    = cnt_width(SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    core_fsm_e          r_state;
    logic [SIZE-1:0]    r_div;
    logic [SIZE-1:0]    r_rem;
    logic [SIZE-1:0]    r_quo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_ready;
    logic               r_valid;
    logic               r_error;
    logic [SIZE-1:0]    r_quotient;
    logic [SIZE-1:0]    r_remainder;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [SIZE-1:0]    w_dvd_mag;
    logic [SIZE-1:0]    w_dvs_mag;
    logic               w_dvs_zero;
    logic [SIZE:0]      w_shift;
    logic               w_fits;
    logic [SIZE-1:0]    w_diff;
    logic [SIZE-1:0]    w_rem_next;
    logic [SIZE-1:0]    w_quo_next;
    logic [SIZE-1:0]    w_quo_fixed;
    logic [SIZE-1:0]    w_rem_fixed;

    // Operand magnitudes; the most negative value maps onto 2^(SIZE-1) unchanged.
    assign w_dvd_neg  = is_signed & dividend[SIZE-1];
    assign w_dvs_neg  = is_signed & divisor[SIZE-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == {SIZE{1'b0}});

    // The shifted partial remainder needs one extra bit before the trial subtract.
    assign w_shift    = {r_rem, r_quo[SIZE-1]};
    assign w_fits     = (w_shift >= {1'b0, r_div});
    assign w_diff     = w_shift[SIZE-1:0] - r_div;
    assign w_rem_next = w_fits ? w_diff : w_shift[SIZE-1:0];
    assign w_quo_next = {r_quo[SIZE-2:0], w_fits};

    assign w_quo_fixed = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fixed = r_neg_r ? -r_rem : r_rem;

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= {SIZE{1'b0}};
            r_rem       <= {SIZE{1'b0}};
            r_quo       <= {SIZE{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_quotient  <= {SIZE{1'b0}};
            r_remainder <= {SIZE{1'b0}};
        end else if (kill) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ready <= 1'b0;
                        if (w_dvs_zero) begin
                            r_state     <= DONE;
                            r_valid     <= 1'b1;
                            r_error     <= 1'b1;
                            r_quotient  <= {SIZE{1'b1}};
                            r_remainder <= dividend;
                        end else begin
                            r_state <= CALC;
                            r_valid <= 1'b0;
                            r_div   <= w_dvs_mag;
                            r_quo   <= w_dvd_mag;
                            r_rem   <= {SIZE{1'b0}};
                            r_cnt   <= {CNT_W{1'b0}};
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_cnt   <= r_cnt + CNT_W'(1'b1);
                    r_ready <= 1'b0;
                    r_valid <= 1'b0;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= SIGN;
                    end else begin
                        r_state <= CALC;
                    end
                end
                SIGN: begin
                    r_state     <= DONE;
                    r_ready     <= 1'b0;
                    r_valid     <= 1'b1;
                    r_error     <= 1'b0;
                    r_quotient  <= w_quo_fixed;
                    r_remainder <= w_rem_fixed;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign valid     = r_valid;
    assign error     = r_error;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (SIZE=33): latency, signed fix-up,
// divide-by-zero, wrap case, kill, ignored start and mid-operation reset.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic        is_signed;
    logic [32:0] dividend;
    logic [32:0] divisor;
    logic        ready;
    logic        valid;
    logic        error;
    logic [32:0] quotient;
    logic [32:0] remainder;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.SIZE(33)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .kill      (kill),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .error     (error),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one start for a single edge; returns just after the accept edge.
    task automatic issue(input logic sg, input logic [32:0] a, input logic [32:0] b);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Edges until valid is seen (0 if already high); -1 when the budget runs out.
    task automatic wait_valid(output int lat);
        lat = -1;
        if (valid === 1'b1) begin
            lat = 0;
        end else begin
            for (int k = 1; k <= 100; k++) begin
                @(posedge clk);
                #1;
                if (valid === 1'b1) begin
                    lat = k;
                    break;
                end
            end
        end
    endtask

    task automatic count_valid(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (valid !== 1'b0) seen++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_checks++;
        if ({ready, valid, error} !== 3'b100) $display("FAIL reset_flags: got %b expected %b", {ready, valid, error}, 3'b100);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 66'd0) $display("FAIL reset_data: got %h/%h expected 0/0", quotient, remainder);
        else n_pass++;
        rst_n = 1'b1;
        tick(1);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", ready);
        else n_pass++;
    endtask

    task automatic test_unsigned();
        int lat;
        issue(1'b0, 33'd100, 33'd7);
        n_checks++;
        if ({ready, valid} !== 2'b00) $display("FAIL busy_flags: got %b expected 00", {ready, valid});
        else n_pass++;
        wait_valid(lat);
        n_checks++;
        if (lat !== 34) $display("FAIL unsigned_latency: got %0d expected 34", lat);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder, error} !== {33'd14, 33'd2, 1'b0}) $display("FAIL unsigned_100_7: got %h/%h err %b expected %h/%h err 0", quotient, remainder, error, 33'd14, 33'd2);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({ready, valid} !== 2'b10) $display("FAIL after_done: got %b expected 10", {ready, valid});
        else n_pass++;
        n_checks++;
        if (quotient !== 33'd14) $display("FAIL hold_q: got %h expected %h", quotient, 33'd14);
        else n_pass++;
        issue(1'b0, 33'h1_FFFF_FFFF, 33'h0_0000_0010);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder} !== {33'h0_1FFF_FFFF, 33'h0_0000_000F}) $display("FAIL unsigned_wide: got %h/%h expected %h/%h", quotient, remainder, 33'h0_1FFF_FFFF, 33'h0_0000_000F);
        else n_pass++;
        tick(1);
        issue(1'b0, 33'd3, 33'd10);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder} !== {33'd0, 33'd3}) $display("FAIL small_dividend: got %h/%h expected 0/3", quotient, remainder);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_signed();
        int lat;
        issue(1'b1, 33'h1_FFFF_FFF9, 33'd2);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder} !== {33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF}) $display("FAIL signed_m7_2: got %h/%h expected %h/%h", quotient, remainder, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF);
        else n_pass++;
        tick(1);
        issue(1'b1, 33'd7, 33'h1_FFFF_FFFE);
        wait_valid(lat);
        n_checks++;
        if (lat !== 34) $display("FAIL signed_latency: got %0d expected 34", lat);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== {33'h1_FFFF_FFFD, 33'd1}) $display("FAIL signed_7_m2: got %h/%h expected %h/%h", quotient, remainder, 33'h1_FFFF_FFFD, 33'd1);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_div_zero();
        int lat;
        issue(1'b1, 33'd5, 33'd0);
        wait_valid(lat);
        n_checks++;
        if (lat !== 0) $display("FAIL divzero_latency: got %0d expected 0", lat);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder, error} !== {33'h1_FFFF_FFFF, 33'd5, 1'b1}) $display("FAIL divzero_result: got %h/%h err %b expected %h/5 err 1", quotient, remainder, error, 33'h1_FFFF_FFFF);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({ready, valid, error} !== 3'b101) $display("FAIL divzero_after: got %b expected 101", {ready, valid, error});
        else n_pass++;
    endtask

    task automatic test_wrap();
        int lat;
        issue(1'b1, 33'h1_8000_0000, 33'h1_FFFF_FFFF);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder, error} !== {33'h0_8000_0000, 33'd0, 1'b0}) $display("FAIL int32min_m1: got %h/%h err %b expected %h/0 err 0", quotient, remainder, error, 33'h0_8000_0000);
        else n_pass++;
        tick(1);
        issue(1'b1, 33'h1_0000_0000, 33'h1_FFFF_FFFF);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder, error} !== {33'h1_0000_0000, 33'd0, 1'b0}) $display("FAIL min_wrap: got %h/%h err %b expected %h/0 err 0", quotient, remainder, error, 33'h1_0000_0000);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_start_ignored();
        int lat;
        issue(1'b0, 33'd100, 33'd7);
        tick(4);
        issue(1'b0, 33'd50, 33'd5);
        wait_valid(lat);
        n_checks++;
        if (lat + 5 !== 34) $display("FAIL ignored_latency: got %0d expected 34", lat + 5);
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== {33'd14, 33'd2}) $display("FAIL ignored_start: got %h/%h expected %h/%h", quotient, remainder, 33'd14, 33'd2);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_kill();
        int lat;
        int seen;
        issue(1'b0, 33'd9, 33'd3);
        wait_valid(lat);
        tick(1);
        issue(1'b0, 33'd1000, 33'd10);
        tick(9);
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        n_checks++;
        if ({ready, valid} !== 2'b10) $display("FAIL kill_idle: got %b expected 10", {ready, valid});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== {33'd3, 33'd0}) $display("FAIL kill_hold: got %h/%h expected 3/0", quotient, remainder);
        else n_pass++;
        count_valid(40, seen);
        n_checks++;
        if (seen !== 0) $display("FAIL kill_no_valid: got %0d pulses expected 0", seen);
        else n_pass++;
        issue(1'b0, 33'd1000, 33'd10);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder, lat} !== {33'd100, 33'd0, 32'sd34}) $display("FAIL after_kill: got %h/%h lat %0d expected %h/0 lat 34", quotient, remainder, lat, 33'd100);
        else n_pass++;
        tick(1);
        // kill and start together in IDLE: start must be dropped
        kill = 1'b1;
        issue(1'b0, 33'd20, 33'd4);
        kill = 1'b0;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL kill_start_ready: got %b expected 1", ready);
        else n_pass++;
        count_valid(40, seen);
        n_checks++;
        if (seen !== 0) $display("FAIL kill_start_dropped: got %0d pulses expected 0", seen);
        else n_pass++;
        // kill while the result is on display
        issue(1'b0, 33'd8, 33'd0);
        n_checks++;
        if (valid !== 1'b1) $display("FAIL kill_done_valid: got %b expected 1", valid);
        else n_pass++;
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        n_checks++;
        if ({ready, valid, error, quotient, remainder} !== {3'b101, 33'h1_FFFF_FFFF, 33'd8}) $display("FAIL kill_done: got %b %h/%h expected 101 %h/8", {ready, valid, error}, quotient, remainder, 33'h1_FFFF_FFFF);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(1'b0, 33'd100, 33'd7);
        wait_valid(lat);
        tick(1);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", ready);
        else n_pass++;
        issue(1'b1, 33'h1_FFFF_FFEC, 33'd6);
        wait_valid(lat);
        n_checks++;
        if ({quotient, remainder, lat} !== {33'h1_FFFF_FFFD, 33'h1_FFFF_FFFE, 32'sd34}) $display("FAIL b2b_m20_6: got %h/%h lat %0d expected %h/%h lat 34", quotient, remainder, lat, 33'h1_FFFF_FFFD, 33'h1_FFFF_FFFE);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(1'b0, 33'd77, 33'd5);
        tick(19);
        rst_n = 1'b0;
        tick(1);
        n_checks++;
        if ({ready, valid, error, quotient, remainder} !== {3'b100, 66'd0}) $display("FAIL mid_reset: got %b %h/%h expected 100 0/0", {ready, valid, error}, quotient, remainder);
        else n_pass++;
        rst_n = 1'b1;
        count_valid(40, seen);
        n_checks++;
        if (seen !== 0) $display("FAIL mid_reset_no_valid: got %0d pulses expected 0", seen);
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        kill      = 1'b0;
        is_signed = 1'b0;
        dividend  = 33'd0;
        divisor   = 33'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_wrap();
        test_start_ignored();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
